// File: rtl/spi_master_rx_wide.sv
// spi_master_rx_wide: multi-lane SPI receive engine.
// Packs 1/2/4-bit beats into DATA_WIDTH words behind a two-deep buffer.
module spi_master_rx_wide #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  abort,
  input  logic                  rx_edge,
  input  logic                  sdi0,
  input  logic                  sdi1,
  input  logic                  sdi2,
  input  logic                  sdi3,
  input  logic [1:0]            mode,
  input  logic                  msb_first,
  input  logic [CNT_WIDTH-1:0]  counter_in,
  input  logic                  counter_in_upd,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  data_last,
  output logic                  rx_done,
  output logic                  clk_en_o
);

  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] WMAX1 = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] WMAX2 = IW'(DATA_WIDTH / 2 - 1);
  localparam logic [IW-1:0] WMAX4 = IW'(DATA_WIDTH / 4 - 1);
  localparam logic [IW-1:0] W_ONE = IW'(1);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH:0] C_ONE_X = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH-1:0] C_RST_TGT = CNT_WIDTH'(8);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECEIVE,
    S_WAIT_FIFO,
    S_WAIT_FIFO_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [CNT_WIDTH-1:0]  r_target;
  logic [CNT_WIDTH-1:0]  r_beat;
  logic [IW-1:0]         r_wcnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_done;
  logic                  r_pend;
  logic                  r_msb;
  logic [1:0]            r_mode;

  logic [1:0]            w_lsel;
  logic [CNT_WIDTH-1:0]  w_tgt_ld;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [CNT_WIDTH:0]    w_beat_inc;
  logic                  w_wfull;
  logic                  w_tlast;
  logic                  w_wdone;
  logic                  w_hs;
  logic                  w_start;
  logic                  w_step;
  logic                  w_ld_new;
  logic                  w_ld_held;
  logic                  w_hold;
  logic                  w_last_ld;
  logic                  w_fin;

  // lane select: 0 single, 1 dual, 2 quad
  always_comb begin
    unique case (r_mode)
      2'b01:   w_lsel = 2'd1;
      2'b10:   w_lsel = 2'd2;
      default: w_lsel = 2'd0;
    endcase
  end

  // length is converted to beats with the live mode input
  always_comb begin
    unique case (mode)
      2'b01:   w_tgt_ld = counter_in >> 1;
      2'b10:   w_tgt_ld = counter_in >> 2;
      default: w_tgt_ld = counter_in;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    w_wfull     = 1'b0;
    unique case (w_lsel)
      2'd1: begin
        w_wfull = (r_wcnt == WMAX2);
        if (r_msb) begin
          w_shift_nxt =
            {r_shift[DATA_WIDTH-3:0], sdi1, sdi0};
        end else begin
          w_shift_nxt[{r_wcnt[IW-2:0], 1'b0} +: 2] =
            {sdi1, sdi0};
        end
      end
      2'd2: begin
        w_wfull = (r_wcnt == WMAX4);
        if (r_msb) begin
          w_shift_nxt = {r_shift[DATA_WIDTH-5:0],
                         sdi3, sdi2, sdi1, sdi0};
        end else begin
          w_shift_nxt[{r_wcnt[IW-3:0], 2'b00} +: 4] =
            {sdi3, sdi2, sdi1, sdi0};
        end
      end
      default: begin
        w_wfull = (r_wcnt == WMAX1);
        if (r_msb) begin
          w_shift_nxt = {r_shift[DATA_WIDTH-2:0], sdi1};
        end else begin
          w_shift_nxt[r_wcnt] = sdi1;
        end
      end
    endcase
  end

  // >= keeps a lowered mid-transfer target from running away
  assign w_beat_inc = {1'b0, r_beat} + C_ONE_X;
  assign w_tlast = (w_beat_inc >= {1'b0, r_target});
  assign w_wdone = w_wfull | w_tlast;
  assign w_hs    = r_valid & data_ready;

  always_comb begin
    w_nxt     = r_state;
    w_start   = 1'b0;
    w_step    = 1'b0;
    w_ld_new  = 1'b0;
    w_ld_held = 1'b0;
    w_hold    = 1'b0;
    w_last_ld = 1'b0;
    w_fin     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          if (r_target == '0) begin
            w_fin = 1'b1;
          end else begin
            w_start = 1'b1;
            w_nxt   = S_RECEIVE;
          end
        end
      end
      S_RECEIVE: begin
        if (rx_edge) begin
          w_step = 1'b1;
          if (w_wdone) begin
            if (!r_valid || w_hs) begin
              w_ld_new  = 1'b1;
              w_last_ld = w_tlast;
              if (w_tlast) w_nxt = S_WAIT_FIFO_DONE;
            end else begin
              w_hold = 1'b1;
              w_nxt  = w_tlast ? S_WAIT_FIFO_DONE
                               : S_WAIT_FIFO;
            end
          end
        end
      end
      S_WAIT_FIFO: begin
        if (w_hs) begin
          w_ld_held = 1'b1;
          w_nxt     = S_RECEIVE;
        end
      end
      S_WAIT_FIFO_DONE: begin
        // r_pend: final word still parked in the shifter
        if (w_hs) begin
          if (r_pend) begin
            w_ld_held = 1'b1;
            w_last_ld = 1'b1;
          end else begin
            w_fin = 1'b1;
            w_nxt = S_IDLE;
          end
        end
      end
      default: w_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_nxt     = S_IDLE;
      w_start   = 1'b0;
      w_step    = 1'b0;
      w_ld_new  = 1'b0;
      w_ld_held = 1'b0;
      w_hold    = 1'b0;
      w_last_ld = 1'b0;
      w_fin     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target <= C_RST_TGT;
      r_beat   <= '0;
      r_wcnt   <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
      r_pend   <= 1'b0;
      r_msb    <= 1'b0;
      r_mode   <= 2'b00;
    end else begin
      if (counter_in_upd) r_target <= w_tgt_ld;
      r_done <= w_fin;
      if (abort) begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        r_beat  <= '0;
        r_wcnt  <= '0;
        r_shift <= '0;
        r_pend  <= 1'b0;
      end else begin
        if (w_hs) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
        end
        if (w_start) begin
          r_mode  <= mode;
          r_msb   <= msb_first;
          r_beat  <= '0;
          r_wcnt  <= '0;
          r_shift <= '0;
          r_pend  <= 1'b0;
        end
        if (w_step) begin
          r_beat <= r_beat + C_ONE;
          if (w_wdone) begin
            r_wcnt  <= '0;
            r_shift <= w_hold ? w_shift_nxt : '0;
            r_pend  <= w_hold;
          end else begin
            r_wcnt  <= r_wcnt + W_ONE;
            r_shift <= w_shift_nxt;
          end
        end
        if (w_ld_new) begin
          r_data  <= w_shift_nxt;
          r_valid <= 1'b1;
          r_last  <= w_last_ld;
        end
        if (w_ld_held) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
          r_last  <= w_last_ld;
          r_shift <= '0;
          r_pend  <= 1'b0;
        end
        if (w_fin) r_beat <= '0;
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_valid;
  assign data_last  = r_last;
  assign rx_done    = r_done;
  assign clk_en_o   = (r_state == S_RECEIVE) & ~w_hold;

endmodule

// File: tb/tb_spi_master_rx_wide.sv
// tb_spi_master_rx_wide: vector table plus corner sequences,
// words checked against a scoreboard queue on each handshake.
module tb_spi_master_rx_wide;

  logic        clk;
  logic        rst;
  logic        en;
  logic        abort;
  logic        rx_edge;
  logic        sdi0, sdi1, sdi2, sdi3;
  logic [1:0]  mode;
  logic        msb_first;
  logic [15:0] counter_in;
  logic        counter_in_upd;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        data_last;
  logic        rx_done;
  logic        clk_en_o;

  spi_master_rx_wide #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .abort(abort),
    .rx_edge(rx_edge),
    .sdi0(sdi0), .sdi1(sdi1), .sdi2(sdi2), .sdi3(sdi3),
    .mode(mode), .msb_first(msb_first),
    .counter_in(counter_in),
    .counter_in_upd(counter_in_upd),
    .data(data), .data_valid(data_valid),
    .data_ready(data_ready), .data_last(data_last),
    .rx_done(rx_done), .clk_en_o(clk_en_o)
  );

  typedef struct {
    logic [1:0]  mode;
    bit          msb;
    int          nbits;
    logic [63:0] seq;
    int          nw;
    logic [31:0] e0;
    logic [31:0] e1;
    int          rdy;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int cyc = 0;
  int done_at = -1;
  int ready_ctl = 0;
  bit hold_prev = 0;
  logic [31:0] pd;
  logic pl;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no event, expected one", nm);
  endtask

  initial begin
    data_ready = 1'b0;
    forever begin
      tick();
      case (ready_ctl)
        0:       data_ready = 1'b0;
        1:       data_ready = 1'b1;
        default: data_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rx_done === 1'b1) done_cnt++;
    if (done_at == cyc) begin
      check("rx_done_timing", 64'(rx_done), 64'd1);
    end
    if (hold_prev) begin
      check("hold_data", 64'(data), 64'(pd));
      check("hold_valid", 64'(data_valid), 64'd1);
      check("hold_last", 64'(data_last), 64'(pl));
    end
    if (!rst && data_valid === 1'b1 && data_ready) begin
      if (sb.size() == 0) begin
        fail_msg("unexpected_word");
      end else begin
        e = sb.pop_front();
        check("word_data", 64'(data), 64'(e.d));
        check("word_last", 64'(data_last), 64'(e.l));
        if (data_last === 1'b1) done_at = cyc + 1;
      end
    end
    hold_prev = !rst && !abort &&
                data_valid === 1'b1 && !data_ready;
    pd = data;
    pl = data_last;
  end

  function automatic int lsel_of(input logic [1:0] m);
    if (m == 2'b01) return 1;
    if (m == 2'b10) return 2;
    return 0;
  endfunction

  function automatic logic [3:0] beat_of(
    input logic [63:0] seq, input bit msb,
    input int k, input int t, input int lsel);
    logic [63:0] s;
    int nb;
    nb = 1 << lsel;
    if (msb) s = seq >> ((t - 1 - k) * nb);
    else     s = seq >> (k * nb);
    return s[3:0] & 4'((1 << nb) - 1);
  endfunction

  task automatic set_lanes(input int lsel,
                           input logic [3:0] b);
    logic [3:0] r;
    r = 4'($urandom);
    case (lsel)
      1: {sdi3, sdi2, sdi1, sdi0} = {r[3:2], b[1:0]};
      2: {sdi3, sdi2, sdi1, sdi0} = b;
      default:
        {sdi3, sdi2, sdi1, sdi0} = {r[3:2], b[0], r[0]};
    endcase
  endtask

  task automatic wait_clken();
    int n;
    n = 0;
    while (!clk_en_o && n < 300) begin
      tick();
      n++;
    end
    if (!clk_en_o) fail_msg("clk_en_timeout");
  endtask

  task automatic push_exp(input logic [31:0] d,
                          input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    sb.push_back(e);
  endtask

  task automatic wait_end(input int d0);
    int n;
    n = 0;
    while ((sb.size() != 0 || done_cnt == d0) && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("rx_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic start(input logic [1:0] m, input bit msb,
                       input int nbits);
    mode = m;
    counter_in = 16'(nbits);
    counter_in_upd = 1'b1;
    tick();
    counter_in_upd = 1'b0;
    msb_first = msb;
    en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic run_rec(input vec_t v);
    int lsel, t, d0;
    lsel = lsel_of(v.mode);
    t = v.nbits >> lsel;
    push_exp(v.e0, v.nw == 1);
    if (v.nw == 2) push_exp(v.e1, 1'b1);
    ready_ctl = v.rdy;
    d0 = done_cnt;
    start(v.mode, v.msb, v.nbits);
    // scramble live mode/order: the transfer must ignore it
    mode = v.mode ^ 2'b11;
    msb_first = ~v.msb;
    for (int k = 0; k < t; k++) begin
      wait_clken();
      set_lanes(lsel, beat_of(v.seq, v.msb, k, t, lsel));
      rx_edge = 1'b1;
      tick();
      rx_edge = 1'b0;
    end
    wait_end(d0);
  endtask

  initial begin
    vec_t v;
    int d0;
    logic [63:0] q;

    tbl[0] = '{2'd0, 1'b1, 32, 64'hA5A5F00F, 1,
               32'hA5A5F00F, 32'h0, 1};
    tbl[1] = '{2'd1, 1'b1, 20, 64'hABCDE, 1,
               32'h000ABCDE, 32'h0, 1};
    tbl[2] = '{2'd0, 1'b0, 8, 64'h01, 1,
               32'h00000001, 32'h0, 1};
    tbl[3] = '{2'd2, 1'b1, 64, 64'h0123456789ABCDEF, 2,
               32'h01234567, 32'h89ABCDEF, 2};
    tbl[4] = '{2'd2, 1'b0, 32, 64'h12345678, 1,
               32'h12345678, 32'h0, 2};
    tbl[5] = '{2'd1, 1'b0, 24, 64'hC0FFEE, 1,
               32'h00C0FFEE, 32'h0, 1};
    tbl[6] = '{2'd0, 1'b1, 40, 64'hDEADBEEF5A, 2,
               32'hDEADBEEF, 32'h0000005A, 2};
    tbl[7] = '{2'd3, 1'b1, 8, 64'h3C, 1,
               32'h0000003C, 32'h0, 1};
    tbl[8] = '{2'd1, 1'b1, 7, 64'h2D, 1,
               32'h0000002D, 32'h0, 1};
    tbl[9] = '{2'd2, 1'b0, 12, 64'hA5C, 1,
               32'h00000A5C, 32'h0, 2};

    rst = 1'b1; en = 1'b0; abort = 1'b0; rx_edge = 1'b0;
    {sdi3, sdi2, sdi1, sdi0} = 4'h0;
    mode = 2'b00; msb_first = 1'b1;
    counter_in = '0; counter_in_upd = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_data", 64'(data), 64'd0);
    check("rst_valid", 64'(data_valid), 64'd0);
    check("rst_last", 64'(data_last), 64'd0);
    check("rst_done", 64'(rx_done), 64'd0);
    check("rst_clken", 64'(clk_en_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_rec(tbl[i]);

    // quad backpressure: second word parks, clock stalls
    ready_ctl = 0;
    d0 = done_cnt;
    q = 64'h0123456789ABCDEF;
    push_exp(32'h01234567, 1'b0);
    push_exp(32'h89ABCDEF, 1'b1);
    start(2'd2, 1'b1, 64);
    for (int k = 0; k < 16; k++) begin
      wait_clken();
      set_lanes(2, beat_of(q, 1'b1, k, 16, 2));
      rx_edge = 1'b1;
      if (k == 15) begin
        @(negedge clk);
        check("stall_clken_comb", 64'(clk_en_o), 64'd0);
      end
      tick();
      rx_edge = 1'b0;
    end
    @(negedge clk);
    check("bp_valid", 64'(data_valid), 64'd1);
    check("bp_data", 64'(data), 64'h01234567);
    check("bp_clken", 64'(clk_en_o), 64'd0);
    tick();
    set_lanes(2, 4'($urandom));
    rx_edge = 1'b1;
    tick();
    rx_edge = 1'b0;
    @(negedge clk);
    check("bp_extra_edge", 64'(data), 64'h01234567);
    check("bp_clken2", 64'(clk_en_o), 64'd0);
    tick();
    ready_ctl = 1;
    wait_end(d0);

    // zero-length transfer
    d0 = done_cnt;
    start(2'd0, 1'b1, 0);
    @(negedge clk);
    check("zero_done", 64'(rx_done), 64'd1);
    check("zero_valid", 64'(data_valid), 64'd0);
    tick();
    @(negedge clk);
    check("zero_done_off", 64'(rx_done), 64'd0);
    check("zero_valid2", 64'(data_valid), 64'd0);
    check("zero_pulses", 64'(done_cnt - d0), 64'd1);
    tick();

    // abort after five beats
    d0 = done_cnt;
    start(2'd0, 1'b1, 16);
    for (int k = 0; k < 5; k++) begin
      wait_clken();
      set_lanes(0, 4'($urandom));
      rx_edge = 1'b1;
      tick();
      rx_edge = 1'b0;
    end
    abort = 1'b1;
    rx_edge = 1'b1;
    tick();
    abort = 1'b0;
    rx_edge = 1'b0;
    @(negedge clk);
    check("abort_clken", 64'(clk_en_o), 64'd0);
    check("abort_valid", 64'(data_valid), 64'd0);
    repeat (4) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    v = '{2'd0, 1'b1, 16, 64'hBEEF, 1,
          32'h0000BEEF, 32'h0, 1};
    run_rec(v);

    // reset while parked in the wait-for-space state
    ready_ctl = 0;
    start(2'd2, 1'b1, 96);
    for (int k = 0; k < 16; k++) begin
      wait_clken();
      set_lanes(2, 4'(k));
      rx_edge = 1'b1;
      tick();
      rx_edge = 1'b0;
    end
    @(negedge clk);
    check("wf_clken", 64'(clk_en_o), 64'd0);
    check("wf_valid", 64'(data_valid), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("wrst_data", 64'(data), 64'd0);
    check("wrst_valid", 64'(data_valid), 64'd0);
    check("wrst_last", 64'(data_last), 64'd0);
    check("wrst_done", 64'(rx_done), 64'd0);
    check("wrst_clken", 64'(clk_en_o), 64'd0);
    tick();
    d0 = done_cnt;
    q = 64'h96;
    push_exp(32'h00000096, 1'b1);
    mode = 2'd0;
    msb_first = 1'b1;
    en = 1'b1;
    tick();
    en = 1'b0;
    ready_ctl = 1;
    for (int k = 0; k < 8; k++) begin
      wait_clken();
      set_lanes(0, beat_of(q, 1'b1, k, 8, 0));
      rx_edge = 1'b1;
      tick();
      rx_edge = 1'b0;
    end
    wait_end(d0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
